// File: rtl/mem_bist_pkg.sv
// Shared types for the memory BIST controller: FSM state encoding,
// address-walk direction and a small state classification helper.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_ASC   = 3'd1,
        ST_RW_RD   = 3'd2,
        ST_RW_WR   = 3'd3,
        ST_R_DESC  = 3'd4,
        ST_R_DRAIN = 3'd5,
        ST_DONE    = 3'd6
    } bist_state_e;

    typedef enum logic {
        DIR_ASC  = 1'b0,
        DIR_DESC = 1'b1
    } bist_dir_e;

    // The controller owns the memory port in every state except the two rest states.
    function automatic logic state_is_busy(input bist_state_e s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage

// File: rtl/mem_bist_checker.sv
// Read-data comparator for the BIST: counts mismatching compares (saturating)
// and remembers the address of the first mismatch since the last clear.
module mem_bist_checker
    import mem_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  cmp_en,
    input  logic [DATA_WIDTH-1:0] expected,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [ADDR_WIDTH-1:0] cmp_addr,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    logic [ADDR_WIDTH+1:0] err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
    logic                  mismatch;

    always_comb begin
        mismatch         = cmp_en && (rdata != expected);
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        if (clear) begin
            err_count_d      = '0;
            first_err_addr_d = '0;
        end else if (mismatch) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
            // Only the very first mismatch of a run is recorded.
            if (err_count_q == '0) begin
                first_err_addr_d = cmp_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q      <= '0;
            first_err_addr_q <= '0;
        end else begin
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-test BIST initiator: writes D ascending, read-D/write-~D ascending,
// then reads ~D descending, and reports pass/fail with error statistics.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;

    bist_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic                  start_ok;
    bist_dir_e             dir;
    logic [ADDR_WIDTH-1:0] addr_step;
    logic                  at_end;
    logic                  cmp_en;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic [ADDR_WIDTH-1:0] cmp_addr;

    // Address walker: only the final read phase runs downwards.
    always_comb begin
        start_ok  = start && !state_is_busy(state_q);
        dir       = (state_q == ST_R_DESC) ? DIR_DESC : DIR_ASC;
        addr_step = (dir == DIR_DESC) ? (addr_q - 1'b1) : (addr_q + 1'b1);
        at_end    = (dir == DIR_DESC) ? (addr_q == ADDR_FIRST) : (addr_q == ADDR_LAST);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pattern_d = pattern_q;
        rd_pend_d = 1'b0;
        rd_addr_d = rd_addr_q;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        cmp_en    = 1'b0;
        cmp_exp   = pattern_q;
        cmp_addr  = addr_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d   = ST_W_ASC;
                    addr_d    = ADDR_FIRST;
                    pattern_d = pattern;
                end
            end
            ST_W_ASC: begin
                mem_wr    = 1'b1;
                mem_wdata = pattern_q;
                if (at_end) begin
                    state_d = ST_RW_RD;
                    addr_d  = ADDR_FIRST;
                end else begin
                    addr_d = addr_step;
                end
            end
            ST_RW_RD: begin
                mem_rd  = 1'b1;
                state_d = ST_RW_WR;
            end
            ST_RW_WR: begin
                // Read data for this address arrives now, so check D and overwrite with ~D.
                mem_wr    = 1'b1;
                mem_wdata = ~pattern_q;
                cmp_en    = 1'b1;
                cmp_exp   = pattern_q;
                cmp_addr  = addr_q;
                if (at_end) begin
                    state_d = ST_R_DESC;
                end else begin
                    addr_d  = addr_step;
                    state_d = ST_RW_RD;
                end
            end
            ST_R_DESC: begin
                mem_rd    = 1'b1;
                rd_pend_d = 1'b1;
                rd_addr_d = addr_q;
                cmp_en    = rd_pend_q;
                cmp_exp   = ~pattern_q;
                cmp_addr  = rd_addr_q;
                if (at_end) begin
                    state_d = ST_R_DRAIN;
                end else begin
                    addr_d = addr_step;
                end
            end
            ST_R_DRAIN: begin
                cmp_en   = rd_pend_q;
                cmp_exp  = ~pattern_q;
                cmp_addr = rd_addr_q;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            pattern_q <= '0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pattern_q <= pattern_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    mem_bist_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_checker (
        .clk            (clk),
        .rst            (rst),
        .clear          (start_ok),
        .cmp_en         (cmp_en),
        .expected       (cmp_exp),
        .rdata          (mem_rdata),
        .cmp_addr       (cmp_addr),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    assign busy     = state_is_busy(state_q);
    assign done     = (state_q == ST_DONE);
    assign pass     = done && (err_count == '0);
    assign mem_addr = addr_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: memory model with injectable read faults, a
// transaction-level model of the march sequence, and directed scenarios.
module tb_mem_bist_ctrl;

    localparam int N  = 256;
    localparam int SN = 4;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] pattern;
    logic        busy, done, pass, mem_rd, mem_wr;
    logic [9:0]  err_count;
    logic [7:0]  first_err_addr, mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        s_start;
    logic [31:0] s_pattern;
    logic        s_busy, s_done, s_pass, s_mem_rd, s_mem_wr;
    logic [3:0]  s_err_count;
    logic [1:0]  s_first_err_addr, s_mem_addr;
    logic [31:0] s_mem_wdata, s_mem_rdata;

    int errors = 0;
    int checks = 0;
    logic cmp_on = 1'b0;

    always #5 clk = ~clk;

    mem_bist_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_bist_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .pattern(s_pattern),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
        .first_err_addr(s_first_err_addr), .mem_rd(s_mem_rd), .mem_wr(s_mem_wr),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
    );

    // Fault configuration applied to data leaving the memory on a read
    logic        stuck_en = 1'b0;
    logic [7:0]  stuck_addr = 8'h00;
    logic [31:0] stuck_mask = 32'h0;
    logic        flip_en = 1'b0;
    logic [7:0]  flip_a0 = 8'h00, flip_a1 = 8'h00;
    logic [31:0] flip_mask = 32'h0;
    logic        s_flip_en = 1'b0;

    function automatic logic [31:0] fault_read(input logic [7:0] a, input logic [31:0] v);
        logic [31:0] r;
        r = v;
        if (stuck_en && a == stuck_addr) r = r & ~stuck_mask;
        if (flip_en && (a == flip_a0 || a == flip_a1)) r = r ^ flip_mask;
        return r;
    endfunction

    logic [31:0] mem [0:N-1];
    logic [31:0] s_mem [0:SN-1];
    initial mem_rdata = 32'h0;
    initial s_mem_rdata = 32'h0;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= fault_read(mem_addr, mem[mem_addr]);
        if (s_mem_wr) s_mem[s_mem_addr] <= s_mem_wdata;
        if (s_mem_rd) s_mem_rdata <= s_mem[s_mem_addr] ^ ((s_flip_en && s_mem_addr == 2'd2) ? 32'h8000_0000 : 32'h0);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Outcome of a whole march run: phase two reads expect D, phase three reads (descending) expect ~D.
    task automatic predict(input logic [31:0] pat, output int cnt, output logic [7:0] first);
        cnt = 0;
        first = 8'h00;
        for (int a = 0; a < N; a++) begin
            if (fault_read(8'(a), pat) != pat) begin
                if (cnt == 0) first = 8'(a);
                cnt++;
            end
        end
        for (int a = N - 1; a >= 0; a--) begin
            if (fault_read(8'(a), ~pat) != ~pat) begin
                if (cnt == 0) first = 8'(a);
                cnt++;
            end
        end
    endtask

    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_k = 0;
    logic [31:0] m_pat = 32'h0;
    int          m_exp_err = 0;
    logic [7:0]  m_exp_first = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_k = 0;
        end else if (!m_busy && start) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_k = 0;
            m_pat = pattern;
            predict(pattern, m_exp_err, m_exp_first);
        end else if (m_busy) begin
            if (m_k == 4 * N) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_k++;
            end
        end
    end

    // Cycle k after accept: k<N write D to k; then pairs (read j, write ~D to j); then read N-1..0; then one quiet cycle.
    always @(negedge clk) begin : compare_proc
        logic        e_rd, e_wr;
        logic [7:0]  e_addr;
        logic [31:0] e_wd;
        int          j;
        if (cmp_on) begin
            e_rd = 1'b0; e_wr = 1'b0; e_addr = 8'h00; e_wd = 32'h0;
            if (m_busy) begin
                if (m_k < N) begin
                    e_wr = 1'b1; e_addr = 8'(m_k); e_wd = m_pat;
                end else if (m_k < 3 * N) begin
                    j = m_k - N;
                    e_addr = 8'(j / 2);
                    if (j % 2 == 0) e_rd = 1'b1;
                    else begin e_wr = 1'b1; e_wd = ~m_pat; end
                end else if (m_k < 4 * N) begin
                    e_rd = 1'b1; e_addr = 8'(4 * N - 1 - m_k);
                end
            end
            checkOutput("mem_rd", 64'(mem_rd), 64'(e_rd));
            checkOutput("mem_wr", 64'(mem_wr), 64'(e_wr));
            checkOutput("mem_wdata", 64'(mem_wdata), 64'(e_wd));
            if (e_rd || e_wr) checkOutput("mem_addr", 64'(mem_addr), 64'(e_addr));
            checkOutput("busy", 64'(busy), 64'(m_busy));
            checkOutput("done", 64'(done), 64'(m_done));
            checkOutput("rd_wr_exclusive", 64'(mem_rd & mem_wr), 64'd0);
            if (!mem_wr) checkOutput("wdata_idle_zero", 64'(mem_wdata), 64'd0);
            if (m_done) begin
                checkOutput("err_count", 64'(err_count), 64'(m_exp_err));
                checkOutput("first_err_addr", 64'(first_err_addr), 64'(m_exp_first));
                checkOutput("pass", 64'(pass), 64'(m_exp_err == 0));
            end else if (!m_busy) begin
                checkOutput("idle_err_count", 64'(err_count), 64'd0);
                checkOutput("idle_pass", 64'(pass), 64'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] pat, output int clks);
        @(negedge clk);
        pattern = pat;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        clks = 0;
        while (done !== 1'b1 && clks < 3000) begin
            @(posedge clk);
            #1 clks++;
        end
    endtask

    task automatic smallRun(input logic [31:0] pat, output int clks);
        @(negedge clk);
        s_pattern = pat;
        s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        checkOutput("small_cleared_err", 64'(s_err_count), 64'd0);
        checkOutput("small_cleared_first", 64'(s_first_err_addr), 64'd0);
        checkOutput("small_cleared_done", 64'(s_done), 64'd0);
        checkOutput("small_busy", 64'(s_busy), 64'd1);
        clks = 0;
        while (s_done !== 1'b1 && clks < 200) begin
            @(posedge clk);
            #1 clks++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int clks;
        rst = 1'b1; start = 1'b0; pattern = 32'h0;
        s_start = 1'b0; s_pattern = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_pass", 64'(pass), 64'd0);
        checkOutput("reset_err", 64'(err_count), 64'd0);
        checkOutput("reset_first", 64'(first_err_addr), 64'd0);
        checkOutput("reset_strobes", 64'({mem_rd, mem_wr}), 64'd0);
        checkOutput("reset_addr", 64'(mem_addr), 64'd0);
        checkOutput("reset_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
        cmp_on = 1'b1;

        $display("[TB] clean memory run");
        applyStimulus(32'hA5A5_5A5A, clks);
        checkOutput("clean_latency", 64'(clks), 64'd1025);
        checkOutput("clean_pass", 64'(pass), 64'd1);
        checkOutput("clean_err", 64'(err_count), 64'd0);

        $display("[TB] stuck-at-0 bit 3 at 0x10");
        stuck_en = 1'b1; stuck_addr = 8'h10; stuck_mask = 32'h0000_0008;
        applyStimulus(32'hFFFF_FFFF, clks);
        checkOutput("stuck_pass", 64'(pass), 64'd0);
        checkOutput("stuck_err", 64'(err_count), 64'd1);
        checkOutput("stuck_first", 64'(first_err_addr), 64'h10);
        stuck_en = 1'b0;

        // Each faulty address is read once in each read phase: 2 addresses x 2 reads.
        $display("[TB] read bit-flip at 0x05 and 0xF0");
        flip_en = 1'b1; flip_a0 = 8'h05; flip_a1 = 8'hF0; flip_mask = 32'h0000_0100;
        applyStimulus(32'h0000_0000, clks);
        checkOutput("flip_pass", 64'(pass), 64'd0);
        checkOutput("flip_err", 64'(err_count), 64'd4);
        checkOutput("flip_first", 64'(first_err_addr), 64'h05);
        flip_en = 1'b0;

        $display("[TB] start while busy, then reset mid-test");
        @(negedge clk);
        pattern = 32'h1357_9BDF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (299) @(posedge clk);
        @(negedge clk);
        pattern = 32'h0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("ignored_start_busy", 64'(busy), 64'd1);
        repeat (298) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_strobes", 64'({mem_rd, mem_wr}), 64'd0);
        rst = 1'b0;
        applyStimulus(32'h0F0F_F0F0, clks);
        checkOutput("restart_latency", 64'(clks), 64'd1025);
        checkOutput("restart_pass", 64'(pass), 64'd1);

        $display("[TB] ADDR_WIDTH=2 back-to-back runs");
        s_flip_en = 1'b1;
        smallRun(32'h1234_5678, clks);
        checkOutput("small1_latency", 64'(clks), 64'd17);
        checkOutput("small1_err", 64'(s_err_count), 64'd2);
        checkOutput("small1_first", 64'(s_first_err_addr), 64'd2);
        checkOutput("small1_pass", 64'(s_pass), 64'd0);
        s_flip_en = 1'b0;
        smallRun(32'hCAFE_0001, clks);
        checkOutput("small2_latency", 64'(clks), 64'd17);
        checkOutput("small2_err", 64'(s_err_count), 64'd0);
        checkOutput("small2_pass", 64'(s_pass), 64'd1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
